// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
//   Shared pipeline constants for the stall/hazard controller.
//   - Default multiply/divide unit latencies (busy cycles).
//   - Encoding of the Tuse/Tnew timing fields (0, 1, 2 cycles).
//   - Width of the MDU busy counter.
//   - Saturating increment helper for 32-bit event counters.
// -----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    // Default MDU latencies; both must fit in the busy counter (1..15).
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // Busy counter width.
    localparam int unsigned MD_CNT_W = 4;

    // Tuse / Tnew encoding: number of cycles until an operand is consumed
    // (Tuse) or a result becomes forwardable (Tnew).
    typedef enum logic [1:0] {
        T_NOW = 2'd0,
        T_ONE = 2'd1,
        T_TWO = 2'd2
    } stage_time_e;

    // Register index 0 is hard-wired to zero and never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        logic [31:0] res;
        res = val;
        if (val != '1) begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_cnt.sv
// -----------------------------------------------------------------------------
// md_busy_cnt
//   Multiply/divide unit occupancy counter.
//   A start accepted while idle loads the op latency; the counter then counts
//   down to zero. Starts arriving while the counter is non-zero are ignored.
//
// Ports
//   clk      in   clock, all state updates on posedge
//   reset    in   synchronous active-high reset (abandons a running op)
//   start    in   MDU op issues this cycle
//   is_div   in   issued op is a divide (0 = multiply)
//   busy     out  MDU occupied: counter non-zero or a start this cycle
//   done     out  registered one-cycle pulse after the counter reaches zero
// -----------------------------------------------------------------------------
module md_busy_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_LAT);
    localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

    // Declaration initialisers mirror the reset values for simulation.
    logic [MD_CNT_W-1:0] cnt    = '0;
    logic                done_q = 1'b0;

    logic                idle;
    logic [MD_CNT_W-1:0] cnt_nxt;

    assign idle = (cnt == '0);

    always_comb begin
        cnt_nxt = cnt;
        if (idle) begin
            if (start) begin
                cnt_nxt = is_div ? DIV_LOAD : MULT_LOAD;
            end
        end else begin
            cnt_nxt = cnt - CNT_ONE;
        end
    end

    // A non-zero count always decrements (starts are ignored while busy), so
    // cnt==1 marks exactly the edge on which the op completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            done_q <= (cnt == CNT_ONE);
        end
    end

    assign busy = !idle || start;
    assign done = done_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Stall controller for a 5-stage pipeline with a multi-cycle MDU.
//   A D-stage instruction stalls when a source register is produced by an
//   older instruction in E or M whose result is not ready in time (Tnew > Tuse),
//   or when it is an MDU instruction and the MDU is busy. Stall freezes PC and
//   F/D and inserts a bubble into D/E. Stalled cycles are counted.
//
// Ports
//   clk                   in   sole clock
//   reset                 in   synchronous active-high reset
//   D_rs_addr, D_rt_addr  in   D-stage source register indices
//   D_rs_tuse, D_rt_tuse  in   cycles until each D-stage operand is consumed
//   D_is_md               in   D-stage op is mult/div/mfhi/mflo/mthi/mtlo
//   E_wa, M_wa            in   destination register index in E / M
//   E_tnew, M_tnew        in   cycles until E / M result is available
//   E_md_start            in   E-stage mult/div issues this cycle
//   E_md_div              in   issued op is div/divu (0 = mult/multu)
//   stall                 out  freeze PC and F/D register
//   PC_WE, FD_WE          out  write enables, inverse of stall
//   DE_clr                out  bubble into D/E, equal to stall
//   md_busy               out  MDU occupied
//   md_done               out  one-cycle pulse when the MDU finishes
//   stall_cnt             out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        PC_WE,
    output logic        FD_WE,
    output logic        DE_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    logic        rs_haz;
    logic        rt_haz;
    logic        md_haz;
    logic [31:0] stall_cnt_q = '0;

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy),
        .done   (md_done)
    );

    // Checking the source index against zero also excludes E_wa/M_wa == 0,
    // since an equality match would then require the source to be zero too.
    always_comb begin
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        if (D_rs_addr != REG_ZERO) begin
            rs_haz = ((D_rs_addr == E_wa) && (E_tnew > D_rs_tuse)) ||
                     ((D_rs_addr == M_wa) && (M_tnew > D_rs_tuse));
        end
        if (D_rt_addr != REG_ZERO) begin
            rt_haz = ((D_rt_addr == E_wa) && (E_tnew > D_rt_tuse)) ||
                     ((D_rt_addr == M_wa) && (M_tnew > D_rt_tuse));
        end
    end

    assign md_haz = D_is_md && md_busy;

    assign stall  = rs_haz || rt_haz || md_haz;
    assign PC_WE  = !stall;
    assign FD_WE  = !stall;
    assign DE_clr = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= sat_inc32(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5: mult/multu busy cycles.
REQ-002 SHALL have parameter DIV_LAT, default 10: div/divu busy cycles.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports D_rs_addr, D_rt_addr  input  5 each  D-stage source registers.
REQ-006 SHALL have ports D_rs_tuse, D_rt_tuse  input  2 each  cycles until D-stage operand is consumed.
REQ-007 SHALL have port D_is_md  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have ports E_wa, M_wa  input  5 each  destination register in E/M.
REQ-009 SHALL have ports E_tnew, M_tnew  input  2 each  cycles until E/M result is available.
REQ-010 SHALL have port E_md_start  input  1  E-stage mult/div issues this cycle.
REQ-011 SHALL have port E_md_div  input  1  issued op is div/divu (0 = mult/multu).
REQ-012 SHALL have port stall  output  1  freeze PC and F/D register.
REQ-013 SHALL have ports PC_WE, FD_WE  output  1 each  equal to ~stall.
REQ-014 SHALL have port DE_clr  output  1  insert bubble into D/E register; equal to stall.
REQ-015 SHALL have port md_busy  output  1  MDU occupied.
REQ-016 SHALL have port md_done  output  1  registered one-cycle pulse when MDU finishes.
REQ-017 SHALL have port stall_cnt  output  32  count of stalled cycles.

Function
REQ-018 SHALL hold 4-bit busy counter cnt; on E_md_start with cnt==0, cnt<=DIV_LAT if E_md_div else MULT_LAT.
REQ-019 SHALL decrement cnt by 1 each cycle while cnt!=0 and no accepted start.
REQ-020 SHALL ignore E_md_start while cnt!=0 (cnt unaffected).
REQ-021 SHALL drive md_busy = (cnt!=0) | E_md_start, combinationally.
REQ-022 SHALL set md_done<=1 for exactly one cycle after the edge on which cnt goes 1->0, else 0.
REQ-023 SHALL flag rs hazard when D_rs_addr!=0 and ((D_rs_addr==E_wa and E_tnew>D_rs_tuse) or (D_rs_addr==M_wa and M_tnew>D_rs_tuse)); rt identical with rt inputs.
REQ-024 SHALL ignore writes to register 0 (E_wa==0 or M_wa==0 never matches).
REQ-025 SHALL flag md hazard when D_is_md and md_busy.
REQ-026 SHALL drive stall = rs hazard | rt hazard | md hazard, purely combinational, zero latency.
REQ-027 SHALL increment stall_cnt on each posedge where stall==1, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL treat simultaneous data and md hazards as a single stall cycle (stall_cnt +1).

Reset
REQ-029 SHALL on reset set cnt=0, md_done=0, stall_cnt=0; md_busy then follows E_md_start only.
REQ-030 SHALL on reset during an MDU operation abandon it with no md_done pulse.
REQ-031 SHALL give reset priority over E_md_start in the same cycle.
REQ-032 SHALL provide initial values matching reset values for simulation.

Structure
REQ-033 SHALL place MULT_LAT/DIV_LAT defaults and tuse/tnew encodings (0,1,2) in the shared pipeline constants package.
REQ-034 SHALL implement the busy counter as sub-module md_busy_cnt; hazard comparison stays in the top module.

Verification
REQ-035 SHALL cover: E_md_start=1, E_md_div=0 at cycle 0 -> md_busy 1 cycles 0..5, md_done=1 at cycle 6 only.
REQ-036 SHALL cover: div start, D_is_md=1 throughout -> stall=1 for 11 cycles, stall_cnt=11.
REQ-037 SHALL cover: D_rs_addr=8, D_rs_tuse=0, E_wa=8, E_tnew=1 -> stall=1, DE_clr=1, PC_WE=0; same with E_wa=0 and D_rs_addr=0 -> stall=0.
REQ-038 SHALL cover: D_rt_addr=9, D_rt_tuse=1, M_wa=9, M_tnew=1 -> stall=0; M_tnew=2 -> stall=1.
REQ-039 SHALL cover: reset asserted at cnt=4 of a div -> cnt=0, md_busy=0, no md_done afterward, stall_cnt=0.
REQ-040 SHALL cover: stall_cnt preloaded by forcing to 32'hFFFF_FFFE, two stall cycles -> stall_cnt=32'hFFFF_FFFF.
